// File: rtl/uart_boot_loader_if.sv
// ---------------------------------------------------------------------------
// uart_boot_loader_if
// Groups the boot loader's UART, instruction-memory and core-control signals.
// Signal prefixes are from the boot loader's point of view (i_ = into the
// loader, o_ = out of the loader).
//   i_rx_data / i_rx_valid   byte stream from the UART receiver
//   i_tx_full                UART transmit FIFO full
//   o_tx_data / o_tx_wr      acknowledge byte and its write strobe
//   o_imem_wen/addr/wdata    instruction-memory write port
//   o_core_reset_n           active-low reset to the core
//   o_boot_done/o_boot_error load status
// modport master: the boot loader.  modport slave: UART, memory, core side.
// ---------------------------------------------------------------------------
interface uart_boot_loader_if #(
  parameter int WIDTH = 32
) ();
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             i_tx_full;
  logic [7:0]       o_tx_data;
  logic             o_tx_wr;
  logic             o_imem_wen;
  logic [WIDTH-1:0] o_imem_addr;
  logic [WIDTH-1:0] o_imem_wdata;
  logic             o_core_reset_n;
  logic             o_boot_done;
  logic             o_boot_error;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_full,
    output o_tx_data, o_tx_wr, o_imem_wen, o_imem_addr, o_imem_wdata,
           o_core_reset_n, o_boot_done, o_boot_error
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_full,
    input  o_tx_data, o_tx_wr, o_imem_wen, o_imem_addr, o_imem_wdata,
           o_core_reset_n, o_boot_done, o_boot_error
  );
endinterface

// File: rtl/uart_boot_loader.sv
// ---------------------------------------------------------------------------
// uart_boot_loader
// Receives a boot image over the UART, writes it word by word into
// instruction memory and keeps the core in reset until the image has been
// accepted. Frame: SYNC, LEN_LO, LEN_HI, 4*LEN data bytes (little endian),
// CSUM = XOR of everything after SYNC. A one-byte ACK goes back on the
// UART transmitter.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      uart_boot_loader_if.master (UART rx/tx, imem write, core ctl)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_SYNC | idle, discarding bytes until SYNC_BYTE
// LEN_LO    | expecting length low byte
// LEN_HI    | expecting length high byte, length range check
// DATA      | collecting data bytes, one imem write per 4 bytes
// CSUM      | expecting checksum byte
// ACK       | holding ACK byte until the transmitter has room
// RUN       | image accepted, core released; terminal until reset
// ---------------------------------------------------------------------------
module uart_boot_loader #(
  parameter int          WIDTH       = 32,
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_OK      = 8'h5A,
  parameter logic [7:0]  ACK_ERR     = 8'hEE,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  uart_boot_loader_if.master bus
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_BITS);

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_LO    = 3'd1,
    S_LEN_HI    = 3'd2,
    S_DATA      = 3'd3,
    S_CSUM      = 3'd4,
    S_ACK       = 3'd5,
    S_RUN       = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [7:0]           r_len_lo;
  logic [15:0]          r_words_left;
  logic [ADDR_BITS-1:0] r_word_idx;
  logic [1:0]           r_byte_cnt;
  logic [23:0]          r_word;
  logic [7:0]           r_csum;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_ack_err;
  logic                 r_boot_error;
  logic                 r_wen;
  logic [WIDTH-1:0]     r_addr;
  logic [WIDTH-1:0]     r_wdata;

  logic                 w_rx_valid;
  logic [7:0]           w_rx_data;
  logic [15:0]          w_len_rx;
  logic                 w_active;
  logic                 w_tmo_hit;
  logic                 w_ack_err;
  logic [WIDTH-1:0]     w_addr;
  logic [7:0]           w_tx_data;
  logic                 w_tx_wr;
  logic                 w_core_reset_n;
  logic                 w_boot_done;

  assign w_rx_valid = bus.i_rx_valid;
  assign w_rx_data  = bus.i_rx_data;
  assign w_len_rx   = {w_rx_data, r_len_lo};
  assign w_active   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                      (r_state == S_DATA)   || (r_state == S_CSUM);
  // Timer is reloaded on every byte, so reaching zero means TIMEOUT_CYC
  // consecutive idle cycles inside the frame.
  assign w_tmo_hit  = w_active && !w_rx_valid && (r_tmo == '0);
  assign w_addr     = WIDTH'(BASE_ADDR) + (WIDTH'(r_word_idx) << 2);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_ack_err marks an entry into ACK with a failure
  always_comb begin
    w_state_nxt = r_state;
    w_ack_err   = 1'b0;
    unique case (r_state)
      S_WAIT_SYNC: begin
        if (w_rx_valid && (w_rx_data == SYNC_BYTE)) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_rx_valid) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_rx_valid) begin
          if ({1'b0, w_len_rx} > MAX_WORDS) begin
            w_state_nxt = S_ACK;
            w_ack_err   = 1'b1;
          end else if (w_len_rx == 16'd0) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_rx_valid && (r_byte_cnt == 2'd3) && (r_words_left == 16'd1))
          w_state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (w_rx_valid) begin
          w_state_nxt = S_ACK;
          w_ack_err   = (w_rx_data != r_csum);
        end
      end
      S_ACK: begin
        if (!bus.i_tx_full) w_state_nxt = r_ack_err ? S_WAIT_SYNC : S_RUN;
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_WAIT_SYNC;
      end
    endcase
    if (w_tmo_hit) begin
      w_state_nxt = S_ACK;
      w_ack_err   = 1'b1;
    end
  end

  // Output logic; tx_wr follows tx_full combinationally so the byte goes
  // out in the very first cycle the FIFO has room.
  always_comb begin
    w_tx_data      = 8'h00;
    w_tx_wr        = 1'b0;
    w_core_reset_n = 1'b0;
    w_boot_done    = 1'b0;
    unique case (r_state)
      S_ACK: begin
        w_tx_data = r_ack_err ? ACK_ERR : ACK_OK;
        w_tx_wr   = !bus.i_tx_full;
      end
      S_RUN: begin
        w_core_reset_n = 1'b1;
        w_boot_done    = 1'b1;
      end
      default: begin
        w_tx_data = 8'h00;
      end
    endcase
  end

  // Datapath: byte assembly, checksum, write port, timer, error flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_tmo        <= '0;
      r_ack_err    <= 1'b0;
      r_boot_error <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_wen <= 1'b0;

      if (!w_active || w_rx_valid) begin
        r_tmo <= TMO_LOAD;
      end else if (r_tmo != '0) begin
        r_tmo <= r_tmo - 1'b1;
      end

      // Latch the verdict on the way into ACK; it is held while in ACK.
      if (r_state != S_ACK) r_ack_err <= w_ack_err;

      unique case (r_state)
        S_WAIT_SYNC: begin
          if (w_rx_valid && (w_rx_data == SYNC_BYTE)) begin
            r_csum       <= '0;
            r_byte_cnt   <= '0;
            r_word_idx   <= '0;
            r_boot_error <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (w_rx_valid) begin
            r_len_lo <= w_rx_data;
            r_csum   <= r_csum ^ w_rx_data;
          end
        end
        S_LEN_HI: begin
          if (w_rx_valid) begin
            r_words_left <= w_len_rx;
            r_csum       <= r_csum ^ w_rx_data;
          end
        end
        S_DATA: begin
          if (w_rx_valid) begin
            r_csum     <= r_csum ^ w_rx_data;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            unique case (r_byte_cnt)
              2'd0: r_word[7:0]   <= w_rx_data;
              2'd1: r_word[15:8]  <= w_rx_data;
              2'd2: r_word[23:16] <= w_rx_data;
              default: begin
                // Lane 3 completes the word: the write issues next cycle
                // straight from registers, so back-to-back bytes never stall.
                r_wen        <= 1'b1;
                r_wdata      <= WIDTH'({w_rx_data, r_word});
                r_addr       <= w_addr;
                r_word_idx   <= r_word_idx + 1'b1;
                r_words_left <= r_words_left - 1'b1;
              end
            endcase
          end
        end
        S_ACK: begin
          if (!bus.i_tx_full && r_ack_err) r_boot_error <= 1'b1;
        end
        default: begin
          r_csum <= r_csum;
        end
      endcase
    end
  end

  assign bus.o_tx_data      = w_tx_data;
  assign bus.o_tx_wr        = w_tx_wr;
  assign bus.o_imem_wen     = r_wen;
  assign bus.o_imem_addr    = r_addr;
  assign bus.o_imem_wdata   = r_wdata;
  assign bus.o_core_reset_n = w_core_reset_n;
  assign bus.o_boot_done    = w_boot_done;
  assign bus.o_boot_error   = r_boot_error;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
  localparam int TMO = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.WIDTH(32)) bus ();

  uart_boot_loader #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct packed {
    logic [7:0] data;
    int         cyc;
  } ack_t;

  typedef struct packed {
    logic [127:0] frm;   // first byte in the most significant used position
    int           n;
    int           gap;
    logic [7:0]   ack;
    int           nw;
    logic [31:0]  w0;
    logic         run;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t        wr_q[$];
  ack_t       ack_q[$];
  int         rxv_q[$];
  logic [7:0] tx_q[$];
  wr_t        mon_w;
  ack_t       mon_a;
  vec_t       vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_imem_wen) begin
      mon_w.addr = bus.o_imem_addr;
      mon_w.data = bus.o_imem_wdata;
      mon_w.cyc  = cyc;
      wr_q.push_back(mon_w);
    end
    if (bus.o_tx_wr) begin
      mon_a.data = bus.o_tx_data;
      mon_a.cyc  = cyc;
      ack_q.push_back(mon_a);
    end
    if (bus.i_rx_valid) rxv_q.push_back(cyc);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_tx_full  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_q.delete();
    ack_q.delete();
    rxv_q.delete();
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send_q(input int gap);
    foreach (tx_q[i]) begin
      bus.i_rx_data  = tx_q[i];
      bus.i_rx_valid = 1'b1;
      tick(1);
      bus.i_rx_valid = 1'b0;
      tick(gap);
    end
  endtask

  task automatic load_q(input logic [127:0] frm, input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(frm[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_acks(input int want, input int budget, input string nm);
    int k;
    k = 0;
    while (ack_q.size() < want && k < budget) begin
      tick(1);
      k++;
    end
    check({nm, " ack seen"}, 128'(ack_q.size() >= want), 128'(1));
  endtask

  function automatic logic [7:0] ack_data(input int i);
    return (ack_q.size() > i) ? ack_q[i].data : 8'h00;
  endfunction

  function automatic logic [127:0] all_outs();
    return {bus.o_tx_data, bus.o_tx_wr, bus.o_imem_wen, bus.o_imem_addr,
            bus.o_imem_wdata, bus.o_core_reset_n, bus.o_boot_done, bus.o_boot_error};
  endfunction

  function automatic vec_t mk(input logic [127:0] frm, input int n, input int gap,
                              input logic [7:0] ack, input int nw,
                              input logic [31:0] w0, input logic run);
    vec_t v;
    v.frm = frm; v.n = n; v.gap = gap; v.ack = ack; v.nw = nw; v.w0 = w0; v.run = run;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [3];
    int          rel_cyc;
    int          last_rx;

    vecs[0] = mk(128'h A5_01_00_13_00_00_00_12, 8, 0, 8'h5A, 1, 32'h0000_0013, 1'b1);
    vecs[1] = mk(128'h A5_01_00_13_00_00_00_13, 8, 0, 8'hEE, 1, 32'h0000_0013, 1'b0);
    vecs[2] = mk(128'h A5_00_00_00,             4, 1, 8'h5A, 0, 32'h0,         1'b1);
    vecs[3] = mk(128'h A5_01_04,                3, 0, 8'hEE, 0, 32'h0,         1'b0);
    vecs[4] = mk(128'h A5_00_00_FF,             4, 0, 8'hEE, 0, 32'h0,         1'b0);
    vecs[5] = mk(128'h 11_22_A5_01_00_78_56_34_12_09, 10, 2, 8'h5A, 1, 32'h1234_5678, 1'b1);

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_tx_full  = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    check("reset outputs", all_outs(), 128'h0);
    #20;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_q(vecs[v].frm, vecs[v].n);
      send_q(vecs[v].gap);
      wait_acks(1, 40, $sformatf("vec%0d", v));
      tick(3);
      check($sformatf("vec%0d ack byte", v), 128'(ack_data(0)), 128'(vecs[v].ack));
      check($sformatf("vec%0d ack count", v), 128'(ack_q.size()), 128'(1));
      check($sformatf("vec%0d writes", v), 128'(wr_q.size()), 128'(vecs[v].nw));
      if (vecs[v].nw > 0 && wr_q.size() > 0) begin
        check($sformatf("vec%0d addr0", v), 128'(wr_q[0].addr), 128'h0);
        check($sformatf("vec%0d word0", v), 128'(wr_q[0].data), 128'(vecs[v].w0));
      end
      check($sformatf("vec%0d boot_done", v), 128'(bus.o_boot_done), 128'(vecs[v].run));
      check($sformatf("vec%0d core_reset_n", v), 128'(bus.o_core_reset_n), 128'(vecs[v].run));
      check($sformatf("vec%0d boot_error", v), 128'(bus.o_boot_error), 128'(!vecs[v].run));
    end

    // Three words back to back
    do_reset();
    exp_w[0] = 32'h0050_0093;
    exp_w[1] = 32'h0010_0113;
    exp_w[2] = 32'hDEAD_BEEF;
    load_q(128'h A5_03_00_93_00_50_00_13_01_10_00_EF_BE_AD_DE_E0, 16);
    send_q(0);
    wait_acks(1, 40, "burst");
    tick(2);
    check("burst ack byte", 128'(ack_data(0)), 128'h5A);
    check("burst writes", 128'(wr_q.size()), 128'(3));
    for (int k = 0; k < 3; k++) begin
      if (wr_q.size() > k && rxv_q.size() > 6 + 4*k) begin
        check($sformatf("burst addr%0d", k), 128'(wr_q[k].addr), 128'(4*k));
        check($sformatf("burst word%0d", k), 128'(wr_q[k].data), 128'(exp_w[k]));
        check($sformatf("burst wen cycle%0d", k), 128'(wr_q[k].cyc), 128'(rxv_q[6+4*k] + 1));
      end
    end
    check("burst boot_done", 128'(bus.o_boot_done), 128'(1));

    // Bad checksum, then retry without reset
    do_reset();
    load_q(128'h A5_01_00_13_00_00_00_13, 8);
    send_q(0);
    wait_acks(1, 40, "retry1");
    tick(2);
    check("retry1 ack byte", 128'(ack_data(0)), 128'hEE);
    check("retry1 boot_error", 128'(bus.o_boot_error), 128'(1));
    check("retry1 core_reset_n", 128'(bus.o_core_reset_n), 128'(0));
    load_q(128'h A5, 1);
    send_q(0);
    check("retry sync clears error", 128'(bus.o_boot_error), 128'(0));
    load_q(128'h 01_00_13_00_00_00_12, 7);
    send_q(0);
    wait_acks(2, 40, "retry2");
    tick(2);
    check("retry2 ack byte", 128'(ack_data(1)), 128'h5A);
    check("retry2 core_reset_n", 128'(bus.o_core_reset_n), 128'(1));
    check("retry2 boot_done", 128'(bus.o_boot_done), 128'(1));

    // Timeout after two of four data bytes
    do_reset();
    load_q(128'h A5_01_00_13_00, 5);
    send_q(0);
    last_rx = (rxv_q.size() > 4) ? rxv_q[4] : 0;
    wait_acks(1, TMO + 10, "timeout");
    check("timeout ack byte", 128'(ack_data(0)), 128'hEE);
    check("timeout latency", 128'((ack_q.size() > 0) ? ack_q[0].cyc - last_rx : -1), 128'(TMO + 1));
    tick(2);
    check("timeout boot_error", 128'(bus.o_boot_error), 128'(1));
    load_q(128'h 01_00_13_00_00_00_12, 7);
    send_q(0);
    tick(10);
    check("timeout junk no ack", 128'(ack_q.size()), 128'(1));
    check("timeout junk no write", 128'(wr_q.size()), 128'(0));
    check("timeout junk not done", 128'(bus.o_boot_done), 128'(0));
    load_q(128'h A5_01_00_13_00_00_00_12, 8);
    send_q(0);
    wait_acks(2, 40, "timeout reload");
    check("timeout reload ack", 128'(ack_data(1)), 128'h5A);

    // tx_full stall in ACK
    do_reset();
    bus.i_tx_full = 1'b1;
    load_q(128'h A5_01_00_13_00_00_00_12, 8);
    send_q(0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d no tx_wr", k), 128'(bus.o_tx_wr), 128'(0));
      check($sformatf("stall%0d tx_data", k), 128'(bus.o_tx_data), 128'h5A);
      tick(1);
    end
    bus.i_tx_full = 1'b0;
    rel_cyc = cyc;
    wait_acks(1, 10, "stall");
    check("stall ack cycle", 128'((ack_q.size() > 0) ? ack_q[0].cyc : -1), 128'(rel_cyc));
    tick(3);
    check("stall ack count", 128'(ack_q.size()), 128'(1));
    check("stall boot_done", 128'(bus.o_boot_done), 128'(1));

    // Reset in the middle of DATA while a write is on the port
    do_reset();
    load_q(128'h A5_03_00_11_22_33_44_55_66_77_88, 11);
    send_q(0);
    check("midreset wen before", 128'(bus.o_imem_wen), 128'(1));
    check("midreset addr before", 128'(bus.o_imem_addr), 128'h4);
    #2 rst_n = 1'b0;
    #1;
    check("midreset outputs", all_outs(), 128'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("midreset core held", 128'(bus.o_core_reset_n), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
